// File: rtl/sr_ff_pkg.sv
// Shared definitions for the sr_ff set/reset flip-flop bank: S=R=1 policy
// encodings and the per-bit next-state function.
package sr_ff_pkg;

  localparam int MODE_HOLD   = 0;
  localparam int MODE_SET    = 1;
  localparam int MODE_RESET  = 2;
  localparam int MODE_TOGGLE = 3;

  // The S=R=1 case always resolves to a known value; unknown modes fall back to hold.
  function automatic logic sr_next(input logic s, input logic r, input logic q,
                                   input int mode);
    logic nxt;
    nxt = q;
    case ({s, r})
      2'b10: nxt = 1'b1;
      2'b01: nxt = 1'b0;
      2'b11: begin
        case (mode)
          MODE_SET:    nxt = 1'b1;
          MODE_RESET:  nxt = 1'b0;
          MODE_TOGGLE: nxt = ~q;
          default:     nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_ff_if.sv
// Signal bundle for the sr_ff bank. The invalid flag exists only when
// SR_FF_INVALID_FLAG_EN is defined.
interface sr_ff_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] R;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;
`ifdef SR_FF_INVALID_FLAG_EN
  logic [WIDTH-1:0] invalid;

  modport master (output S, output R, input Q, input Qbar, input invalid);
  modport slave  (input S, input R, output Q, output Qbar, output invalid);
`else
  modport master (output S, output R, input Q, input Qbar);
  modport slave  (input S, input R, output Q, output Qbar);
`endif
endinterface

// File: rtl/sr_ff_cell.sv
// Single SR storage bit with asynchronous active-high reset; the S=R=1
// behaviour is fixed by BOTH_MODE.
module sr_ff_cell
  import sr_ff_pkg::*;
#(
  parameter int BOTH_MODE = MODE_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic s_i,
  input  logic r_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = sr_next(s_i, r_i, q_q, BOTH_MODE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/sr_ff.sv
// Bank of WIDTH independent clocked SR flip-flops with Q and Qbar outputs.
// Defining SR_FF_INVALID_FLAG_EN adds a registered per-bit S&R flag.
module sr_ff
  import sr_ff_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int BOTH_MODE = MODE_HOLD
) (
  input  logic    clk,
  input  logic    rst,
  sr_ff_if.slave  bus
);

  logic [WIDTH-1:0] q;

  if (BOTH_MODE < MODE_HOLD || BOTH_MODE > MODE_TOGGLE) begin : g_bad_mode
    $error("sr_ff: BOTH_MODE must be 0..3");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_ff_cell #(
      .BOTH_MODE (BOTH_MODE)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .s_i (bus.S[i]),
      .r_i (bus.R[i]),
      .q_o (q[i])
    );
  end

  // Qbar comes from the same register so the pair can never disagree.
  assign bus.Q    = q;
  assign bus.Qbar = ~q;

`ifdef SR_FF_INVALID_FLAG_EN
  logic [WIDTH-1:0] invalid_q;
  logic [WIDTH-1:0] invalid_d;

  assign invalid_d = bus.S & bus.R;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      invalid_q <= '0;
    end else begin
      invalid_q <= invalid_d;
    end
  end

  assign bus.invalid = invalid_q;
`endif

endmodule

// File: tb/tb_sr_ff.sv
// Directed bench for sr_ff: four 1-bit instances (one per BOTH_MODE) sharing
// S/R, plus a 4-bit instance; optional invalid flag checked when enabled.
module tb_sr_ff;

  logic clk;
  logic rst;
  logic s1, r1;
  logic [3:0] s4, r4;

  int n_tests;
  int n_fail;

  sr_ff_if #(.WIDTH(1)) if0 ();
  sr_ff_if #(.WIDTH(1)) if1 ();
  sr_ff_if #(.WIDTH(1)) if2 ();
  sr_ff_if #(.WIDTH(1)) if3 ();
  sr_ff_if #(.WIDTH(4)) if4 ();

  assign if0.S = s1;  assign if0.R = r1;
  assign if1.S = s1;  assign if1.R = r1;
  assign if2.S = s1;  assign if2.R = r1;
  assign if3.S = s1;  assign if3.R = r1;
  assign if4.S = s4;  assign if4.R = r4;

  sr_ff #(.WIDTH(1), .BOTH_MODE(0)) u_hold   (.clk(clk), .rst(rst), .bus(if0));
  sr_ff #(.WIDTH(1), .BOTH_MODE(1)) u_set    (.clk(clk), .rst(rst), .bus(if1));
  sr_ff #(.WIDTH(1), .BOTH_MODE(2)) u_reset  (.clk(clk), .rst(rst), .bus(if2));
  sr_ff #(.WIDTH(1), .BOTH_MODE(3)) u_toggle (.clk(clk), .rst(rst), .bus(if3));
  sr_ff #(.WIDTH(4), .BOTH_MODE(0)) u_wide   (.clk(clk), .rst(rst), .bus(if4));

  // Clock: posedges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_until(input int t);
    if ($time < t) #(t - $time);
  endtask

  task automatic check_all1(input string tag, input logic e0, input logic e1,
                            input logic e2, input logic e3);
    check({tag, "_m0_q"}, 32'(if0.Q), 32'(e0));
    check({tag, "_m1_q"}, 32'(if1.Q), 32'(e1));
    check({tag, "_m2_q"}, 32'(if2.Q), 32'(e2));
    check({tag, "_m3_q"}, 32'(if3.Q), 32'(e3));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    s1 = 1'b0; r1 = 1'b0;
    s4 = 4'b0000; r4 = 4'b0000;

    // Reset state before any clock edge
    wait_until(2);
    check_all1("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_qbar", 32'(if0.Qbar), 32'h1);
    check("reset_w4_q", 32'(if4.Q), 32'h0);
    check("reset_w4_qbar", 32'(if4.Qbar), 32'hf);
`ifdef SR_FF_INVALID_FLAG_EN
    check("reset_w4_invalid", 32'(if4.invalid), 32'h0);
`endif
    wait_until(3);
    rst = 1'b0;

    // Two idle edges (5, 15)
    wait_until(16);
    check("idle_q", 32'(if0.Q), 32'h0);

    // Set / reset / hold / S=R=1 sequence on the 1-bit instances
    wait_until(21); s1 = 1'b1; r1 = 1'b0;
    wait_until(26);
    check_all1("set", 1'b1, 1'b1, 1'b1, 1'b1);
    check("set_qbar", 32'(if0.Qbar), 32'h0);

    wait_until(31); s1 = 1'b0; r1 = 1'b1;
    wait_until(36);
    check_all1("clr", 1'b0, 1'b0, 1'b0, 1'b0);
    check("clr_qbar", 32'(if0.Qbar), 32'h1);

    wait_until(41); s1 = 1'b0; r1 = 1'b0;
    wait_until(46);
    check_all1("hold", 1'b0, 1'b0, 1'b0, 1'b0);

    // S=R=1 from Q=0: edges at 55 and 65
    wait_until(51); s1 = 1'b1; r1 = 1'b1;
    wait_until(56);
    check_all1("both0_e1", 1'b0, 1'b1, 1'b0, 1'b1);
    check("both0_m3_qbar", 32'(if3.Qbar), 32'h0);
    wait_until(66);
    check_all1("both0_e2", 1'b0, 1'b1, 1'b0, 1'b0);

    // Bring all to 1, then S=R=1 from Q=1: edges at 85 and 95
    wait_until(71); s1 = 1'b1; r1 = 1'b0;
    wait_until(76);
    check_all1("preset", 1'b1, 1'b1, 1'b1, 1'b1);
    wait_until(81); s1 = 1'b1; r1 = 1'b1;
    wait_until(86);
    check_all1("both1_e1", 1'b1, 1'b1, 1'b0, 1'b0);
    wait_until(96);
    check_all1("both1_e2", 1'b1, 1'b1, 1'b0, 1'b1);

    // Async reset between edges with Q=1
    wait_until(101); s1 = 1'b1; r1 = 1'b0;
    wait_until(106);
    check_all1("pre_arst", 1'b1, 1'b1, 1'b1, 1'b1);
    wait_until(107); rst = 1'b1;
    wait_until(108);
    check_all1("arst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("arst_qbar", 32'(if0.Qbar), 32'h1);
    wait_until(110); rst = 1'b0;

    // Wide instance from reset, S still 1 on the narrow ones
    wait_until(111); s4 = 4'b1010; r4 = 4'b0101;
    wait_until(116);
    check_all1("post_arst", 1'b1, 1'b1, 1'b1, 1'b1);
    check("w4_q", 32'(if4.Q), 32'ha);
    check("w4_qbar", 32'(if4.Qbar), 32'h5);

    // Stability: wiggle S/R between edges, no edge occurs until 125
    wait_until(118); s1 = 1'b0; r1 = 1'b1;
    wait_until(119); s1 = 1'b1; r1 = 1'b1;
    wait_until(120); s1 = 1'b0; r1 = 1'b1;
    wait_until(121); s4 = 4'b0011; r4 = 4'b0011;
    wait_until(122); s1 = 1'b1; r1 = 1'b0;
    wait_until(123); s1 = 1'b0; r1 = 1'b1;
    check_all1("stable", 1'b1, 1'b1, 1'b1, 1'b1);
    wait_until(124); s1 = 1'b0; r1 = 1'b0;
    wait_until(126);
    check("stable_after_edge", 32'(if0.Q), 32'h1);
    check("w4_both_q", 32'(if4.Q), 32'ha);
`ifdef SR_FF_INVALID_FLAG_EN
    check("w4_invalid_set", 32'(if4.invalid), 32'h3);
`endif
    wait_until(131); s4 = 4'b0000; r4 = 4'b0000;
    wait_until(136);
    check("w4_hold_q", 32'(if4.Q), 32'ha);
`ifdef SR_FF_INVALID_FLAG_EN
    check("w4_invalid_clr", 32'(if4.invalid), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
